// File: rtl/pooling_max_window_pkg.sv
// Shared pooling parameters: word width, feature count and index widths
// used by the max-pooling window, its interface and its comparator.
package pooling_max_window_pkg;

  localparam int POOL_DATA_WIDTH    = 32;
  localparam int POOL_TOTAL_FEATURE = 4;
  localparam int POOL_FEATURE_WIDTH = 2;
  localparam int POOL_ROW_WIDTH     = 3;
  localparam int POOL_ROW_LEN       = 6;

endpackage

// File: rtl/pooling_max_window_if.sv
// Pixel stream into the 2x2 max-pooling window and pooled result out of it.
// The slave side is the pooling block; the master side is whoever feeds it.
interface pooling_max_window_if
  import pooling_max_window_pkg::*;
#(
  parameter int DATA_WIDTH    = POOL_DATA_WIDTH,
  parameter int FEATURE_WIDTH = POOL_FEATURE_WIDTH,
  parameter int ROW_WIDTH     = POOL_ROW_WIDTH
) ();

  logic [DATA_WIDTH-1:0]    data_in;
  logic                     input_valid;
  logic [FEATURE_WIDTH-1:0] in_feature_idx;
  logic [ROW_WIDTH-1:0]     in_row;
  logic [ROW_WIDTH-1:0]     in_col;

  logic [DATA_WIDTH-1:0]    data_out;
  logic                     output_valid;
  logic [FEATURE_WIDTH-1:0] feature_idx;
  logic [ROW_WIDTH-1:0]     feature_row;
  logic                     seq_error;

  modport slave (
    input  data_in, input_valid, in_feature_idx, in_row, in_col,
    output data_out, output_valid, feature_idx, feature_row, seq_error
  );

  modport master (
    output data_in, input_valid, in_feature_idx, in_row, in_col,
    input  data_out, output_valid, feature_idx, feature_row, seq_error
  );

endinterface

// File: rtl/pooling_max_window_fp_max.sv
// Combinational maximum of two IEEE-754 single-precision words without
// unpacking them: sign decides first, then raw magnitude bits. Two zeros
// of either sign return the first operand. NaN is not handled.
module pooling_max_window_fp_max #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  logic                  a_neg;
  logic                  b_neg;
  logic [DATA_WIDTH-2:0] a_mag;
  logic [DATA_WIDTH-2:0] b_mag;

  assign a_neg = a[DATA_WIDTH-1];
  assign b_neg = b[DATA_WIDTH-1];
  assign a_mag = a[DATA_WIDTH-2:0];
  assign b_mag = b[DATA_WIDTH-2:0];

  // Pick the larger operand; among negatives the smaller magnitude wins
  always_comb begin
    y = a;
    if (a_mag == '0 && b_mag == '0) begin
      y = a;
    end else if (a_neg != b_neg) begin
      y = a_neg ? b : a;
    end else if (!a_neg) begin
      y = (b_mag > a_mag) ? b : a;
    end else begin
      y = (b_mag < a_mag) ? b : a;
    end
  end

endmodule

// File: rtl/pooling_max_window.sv
// Streaming 2x2 max-pooling for interleaved feature maps. Even columns park
// in a per-feature horizontal register, odd columns fold it into a
// horizontal max; even rows park that in a per-feature line buffer and odd
// rows fold the line buffer in and emit the pooled pixel one cycle later.
module pooling_max_window
  import pooling_max_window_pkg::*;
#(
  parameter int DATA_WIDTH    = POOL_DATA_WIDTH,
  parameter int TOTAL_FEATURE = POOL_TOTAL_FEATURE,
  parameter int FEATURE_WIDTH = POOL_FEATURE_WIDTH,
  parameter int ROW_WIDTH     = POOL_ROW_WIDTH,
  parameter int ROW_LEN       = POOL_ROW_LEN
) (
  input logic                  clk,
  input logic                  rst_n,
  pooling_max_window_if.slave  bus
);

  localparam int HALF_LEN = ROW_LEN / 2;

  logic [DATA_WIDTH-1:0]    h      [TOTAL_FEATURE];
  logic [TOTAL_FEATURE-1:0] h_vld;
  logic [DATA_WIDTH-1:0]    lb     [TOTAL_FEATURE][HALF_LEN];
  logic                     lb_vld [TOTAL_FEATURE][HALF_LEN];

  logic [FEATURE_WIDTH-1:0] f;
  logic [ROW_WIDTH-2:0]     k;
  logic                     in_range;
  logic                     accept;
  logic [DATA_WIDTH-1:0]    hmax;
  logic [DATA_WIDTH-1:0]    vmax;

  assign f        = bus.in_feature_idx;
  assign k        = bus.in_col[ROW_WIDTH-1:1];
  assign in_range = (int'(bus.in_col) < ROW_LEN) &&
                    (int'(bus.in_feature_idx) < TOTAL_FEATURE);
  assign accept   = bus.input_valid && in_range;

  pooling_max_window_fp_max #(.DATA_WIDTH(DATA_WIDTH)) u_fp_max_h (
    .a (h[f]),
    .b (bus.data_in),
    .y (hmax)
  );

  pooling_max_window_fp_max #(.DATA_WIDTH(DATA_WIDTH)) u_fp_max_v (
    .a (lb[f][k]),
    .b (hmax),
    .y (vmax)
  );

  // Window state update and registered pooled output with sticky error
  always_ff @(posedge clk) begin
    if (rst_n) begin
      bus.data_out     <= '0;
      bus.output_valid <= 1'b0;
      bus.feature_idx  <= '0;
      bus.feature_row  <= '0;
      bus.seq_error    <= 1'b0;
      h_vld            <= '0;
      for (int i = 0; i < TOTAL_FEATURE; i++) begin
        h[i] <= '0;
        for (int j = 0; j < HALF_LEN; j++) begin
          lb[i][j]     <= '0;
          lb_vld[i][j] <= 1'b0;
        end
      end
    end else begin
      bus.output_valid <= 1'b0;
      if (bus.input_valid && !in_range) begin
        bus.seq_error <= 1'b1;
      end
      if (accept) begin
        if (!bus.in_col[0]) begin
          h[f]     <= bus.data_in;
          h_vld[f] <= 1'b1;
        end else begin
          h_vld[f] <= 1'b0;
          if (!h_vld[f]) begin
            bus.seq_error <= 1'b1;
          end
          if (!bus.in_row[0]) begin
            lb[f][k]     <= hmax;
            lb_vld[f][k] <= 1'b1;
          end else begin
            if (!lb_vld[f][k]) begin
              bus.seq_error <= 1'b1;
            end
            lb_vld[f][k]     <= 1'b0;
            bus.data_out     <= vmax;
            bus.feature_idx  <= f;
            bus.feature_row  <= bus.in_row;
            bus.output_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pooling_max_window.sv
// Self-checking bench for the 2x2 max-pooling window: a per-cycle reference
// model built on a signed total order of float words, plus literal checks.
module tb_pooling_max_window;

  localparam int NF = 4;
  localparam int RL = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  bit   cmp_en = 1'b0;

  int checks = 0;
  int failures = 0;

  pooling_max_window_if bus ();

  pooling_max_window dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference state and expected outputs
  logic [31:0] m_even     [NF];
  bit          m_even_vld [NF];
  logic [31:0] m_top      [NF][RL/2];
  bit          m_top_vld  [NF][RL/2];
  logic        exp_valid = 1'b0;
  logic [31:0] exp_data = '0;
  logic [1:0]  exp_feat = '0;
  logic [2:0]  exp_row = '0;
  logic        exp_err = 1'b0;

  logic [31:0] cap_data [$];
  logic [31:0] cap_feat [$];

  // Float max via a signed ordering key; equal keys keep the first operand
  function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b);
    longint ka;
    longint kb;
    ka = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
    kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
    return (kb > ka) ? b : a;
  endfunction

  function automatic logic [31:0] make_val(input int f, input int r, input int c);
    logic [31:0] v;
    v[31]    = ((f + r + c) % 3 == 0);
    v[30:23] = 8'(120 + (f * 7 + c * 3 + r * 5) % 10);
    v[22:0]  = 23'(f * 1000 + c * 77 + r * 13);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: evaluates each accepted pixel against the pooling rules
  always @(posedge clk) begin
    int f, r, c;
    logic [31:0] pair;
    if (rst_n) begin
      for (int i = 0; i < NF; i++) begin
        m_even[i] = '0;
        m_even_vld[i] = 1'b0;
        for (int j = 0; j < RL / 2; j++) begin
          m_top[i][j] = '0;
          m_top_vld[i][j] = 1'b0;
        end
      end
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_feat  = '0;
      exp_row   = '0;
      exp_err   = 1'b0;
    end else begin
      exp_valid = 1'b0;
      if (bus.input_valid) begin
        f = int'(bus.in_feature_idx);
        r = int'(bus.in_row);
        c = int'(bus.in_col);
        if (c >= RL || f >= NF) begin
          exp_err = 1'b1;
        end else if (c % 2 == 0) begin
          m_even[f] = bus.data_in;
          m_even_vld[f] = 1'b1;
        end else begin
          pair = ref_max(m_even[f], bus.data_in);
          if (!m_even_vld[f]) exp_err = 1'b1;
          m_even_vld[f] = 1'b0;
          if (r % 2 == 0) begin
            m_top[f][c / 2] = pair;
            m_top_vld[f][c / 2] = 1'b1;
          end else begin
            if (!m_top_vld[f][c / 2]) exp_err = 1'b1;
            m_top_vld[f][c / 2] = 1'b0;
            exp_valid = 1'b1;
            exp_data  = ref_max(m_top[f][c / 2], pair);
            exp_feat  = 2'(f);
            exp_row   = 3'(r);
          end
        end
      end
    end
  end

  // Compare process: every output against the model on every cycle
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("output_valid", 32'(bus.output_valid), 32'(exp_valid));
      checkOutput("data_out", bus.data_out, exp_data);
      checkOutput("feature_idx", 32'(bus.feature_idx), 32'(exp_feat));
      checkOutput("feature_row", 32'(bus.feature_row), 32'(exp_row));
      checkOutput("seq_error", 32'(bus.seq_error), 32'(exp_err));
      if (bus.output_valid === 1'b1) begin
        cap_data.push_back(bus.data_out);
        cap_feat.push_back(32'(bus.feature_idx));
      end
    end
  end

  task automatic applyStimulus(input int f, input int r, input int c, input logic [31:0] d);
    bus.in_feature_idx = 2'(f);
    bus.in_row         = 3'(r);
    bus.in_col         = 3'(c);
    bus.data_in        = d;
    bus.input_valid    = 1'b1;
    @(posedge clk);
    #1;
    bus.input_valid    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset(input int n);
    rst_n = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.input_valid    = 1'b0;
    bus.data_in        = '0;
    bus.in_feature_idx = '0;
    bus.in_row         = '0;
    bus.in_col         = '0;

    @(posedge clk);
    #1;
    cmp_en = 1'b1;
    checkOutput("reset_valid", 32'(bus.output_valid), 32'd0);
    checkOutput("reset_seq_error", 32'(bus.seq_error), 32'd0);
    doReset(2);
    $display("[TB] reset released");

    // Basic window on feature 0: max of 1.0, 2.0, -1.0, 0.5
    applyStimulus(0, 0, 0, 32'h3F800000);
    applyStimulus(0, 0, 1, 32'h40000000);
    applyStimulus(0, 1, 0, 32'hBF800000);
    applyStimulus(0, 1, 1, 32'h3F000000);
    checkOutput("basic_valid", 32'(bus.output_valid), 32'd1);
    checkOutput("basic_data", bus.data_out, 32'h40000000);
    checkOutput("basic_row", 32'(bus.feature_row), 32'd1);
    checkOutput("model_basic", exp_data, 32'h40000000);
    idle(1);
    checkOutput("basic_pulse_end", 32'(bus.output_valid), 32'd0);
    checkOutput("basic_hold", bus.data_out, 32'h40000000);

    // All-negative window on feature 1, cols 2/3
    applyStimulus(1, 0, 2, 32'hBF800000);
    applyStimulus(1, 0, 3, 32'hC0000000);
    applyStimulus(1, 1, 2, 32'hC0400000);
    applyStimulus(1, 1, 3, 32'hBFC00000);
    checkOutput("neg_data", bus.data_out, 32'hBF800000);
    checkOutput("neg_feat", 32'(bus.feature_idx), 32'd1);
    checkOutput("model_neg", ref_max(32'hC0000000, 32'hBF800000), 32'hBF800000);
    idle(2);

    // Reset clears previously non-zero outputs
    doReset(1);
    checkOutput("rst_data", bus.data_out, 32'd0);
    checkOutput("rst_feat", 32'(bus.feature_idx), 32'd0);
    checkOutput("rst_row", 32'(bus.feature_row), 32'd0);

    // Odd column with no preceding even column: sticky error
    applyStimulus(0, 0, 1, 32'h3F800000);
    checkOutput("seq_set", 32'(bus.seq_error), 32'd1);
    idle(4);
    checkOutput("seq_sticky", 32'(bus.seq_error), 32'd1);
    doReset(1);
    checkOutput("seq_cleared", 32'(bus.seq_error), 32'd0);

    // Signed zeros: +0 leads, -0 elsewhere
    applyStimulus(2, 0, 4, 32'h00000000);
    applyStimulus(2, 0, 5, 32'h80000000);
    applyStimulus(2, 1, 4, 32'h80000000);
    applyStimulus(2, 1, 5, 32'h80000000);
    checkOutput("zero_data", bus.data_out, 32'h00000000);
    checkOutput("zero_valid", 32'(bus.output_valid), 32'd1);
    idle(2);

    // Four features interleaved every cycle over rows 0-1, full width
    cap_data.delete();
    cap_feat.delete();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < RL; c++)
        for (int f = 0; f < NF; f++)
          applyStimulus(f, r, c, make_val(f, r, c));
    idle(2);
    checkOutput("inter_count", 32'(cap_data.size()), 32'd12);
    if (cap_data.size() == 12) begin
      checkOutput("inter_first", cap_data[0], 32'h4000005A);
      checkOutput("inter_feat3", cap_feat[3], 32'd3);
    end
    checkOutput("inter_no_err", 32'(bus.seq_error), 32'd0);

    // Out-of-range columns are ignored but flag an error
    doReset(1);
    applyStimulus(0, 0, 0, 32'h3F800000);
    applyStimulus(0, 0, 6, 32'h42000000);
    checkOutput("range_err", 32'(bus.seq_error), 32'd1);
    applyStimulus(0, 0, 1, 32'h3F000000);
    applyStimulus(0, 1, 0, 32'h3E800000);
    applyStimulus(0, 1, 7, 32'h42000000);
    applyStimulus(0, 1, 1, 32'h3E000000);
    checkOutput("range_data", bus.data_out, 32'h3F800000);
    idle(2);

    // Reset mid-window then replay rows 0-1
    doReset(1);
    for (int c = 0; c < RL; c++) applyStimulus(0, 0, c, 32'h42C80000);
    applyStimulus(0, 1, 0, 32'h42C80000);
    doReset(2);
    cap_data.delete();
    cap_feat.delete();
    applyStimulus(0, 0, 0, 32'h3F800000);
    applyStimulus(0, 0, 1, 32'h40000000);
    applyStimulus(0, 0, 2, 32'h40400000);
    applyStimulus(0, 0, 3, 32'h40800000);
    applyStimulus(0, 0, 4, 32'h40A00000);
    applyStimulus(0, 0, 5, 32'h40C00000);
    for (int c = 0; c < RL; c++) applyStimulus(0, 1, c, 32'h3F000000);
    idle(2);
    checkOutput("replay_count", 32'(cap_data.size()), 32'd3);
    if (cap_data.size() == 3) begin
      checkOutput("replay_0", cap_data[0], 32'h40000000);
      checkOutput("replay_1", cap_data[1], 32'h40800000);
      checkOutput("replay_2", cap_data[2], 32'h40C00000);
    end
    checkOutput("replay_no_err", 32'(bus.seq_error), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pooling_max_window.md
POOLING_MAX_WINDOW -- requirements
Module: pooling_max_window

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning IEEE-754 single-precision word width.
REQ-002 SHALL have parameter TOTAL_FEATURE, default 4, meaning number of interleaved feature maps.
REQ-003 SHALL have parameter FEATURE_WIDTH, default 2, meaning width of the feature index.
REQ-004 SHALL have parameter ROW_WIDTH, default 3, meaning width of the row and column indices.
REQ-005 SHALL have parameter ROW_LEN, default 6, meaning input columns per row (even).
REQ-006 SHALL have port clk, input, 1, meaning single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1, meaning reset: synchronous and active-high (asserted = 1).
REQ-008 SHALL have port data_in, input, DATA_WIDTH, meaning conv-layer output pixel (float).
REQ-009 SHALL have port input_valid, input, 1, meaning data_in and the indices are valid this cycle.
REQ-010 SHALL have port in_feature_idx, input, FEATURE_WIDTH, meaning feature map of data_in.
REQ-011 SHALL have port in_row, input, ROW_WIDTH, meaning input row of data_in.
REQ-012 SHALL have port in_col, input, ROW_WIDTH, meaning input column of data_in.
REQ-013 SHALL have port data_out, output, DATA_WIDTH, meaning 2x2 max-pooled result.
REQ-014 SHALL have port output_valid, output, 1, meaning data_out and indices valid (feeds the pooling output interface input_valid).
REQ-015 SHALL have port feature_idx, output, FEATURE_WIDTH, meaning feature map of data_out.
REQ-016 SHALL have port feature_row, output, ROW_WIDTH, meaning input row that completed the window (always odd).
REQ-017 SHALL have port seq_error, output, 1, meaning sticky flag: a window half was missing.

Function
REQ-018 SHALL treat each accepted pixel (input_valid=1) independently; features may interleave arbitrarily cycle by cycle.
REQ-019 SHALL compute max with fp_max: differing signs -> non-negative operand; both non-negative -> larger magnitude bits; both negative -> smaller magnitude bits; +0 vs -0 -> first operand; NaN unsupported.
REQ-020 SHALL, on even in_col, store data_in into per-feature horizontal register h[f] and set h_vld[f].
REQ-021 SHALL, on odd in_col, form hmax = fp_max(h[f], data_in) and clear h_vld[f].
REQ-022 SHALL, on odd in_col with even in_row, write hmax into line buffer lb[f][in_col/2] and set lb_vld[f][in_col/2].
REQ-023 SHALL, on odd in_col with odd in_row, register data_out = fp_max(lb[f][in_col/2], hmax), feature_idx = f, feature_row = in_row, and clear lb_vld[f][in_col/2].
REQ-024 SHALL assert output_valid for exactly one cycle, the cycle after the completing input (latency 1); no other input produces output.
REQ-025 SHALL hold data_out, feature_idx, feature_row when output_valid=0.
REQ-026 SHALL set seq_error when an odd-column pixel arrives with h_vld[f]=0, or an odd-row window completes with lb_vld entry 0; result still emitted using stored contents.
REQ-027 SHALL allow back-to-back valid inputs every cycle with no stall; a same-cycle write and read of one lb entry cannot occur (different row parity).
REQ-028 SHALL ignore inputs with in_col >= ROW_LEN or in_feature_idx >= TOTAL_FEATURE and set seq_error.

Reset
REQ-029 SHALL, while rst_n=1 at a clock edge, clear data_out, feature_idx, feature_row, output_valid, seq_error, all h, h_vld, lb, lb_vld to 0.
REQ-030 SHALL, when reset is asserted mid-window, discard partial windows; first output after release requires complete fresh windows.

Structure
REQ-031 SHALL take DATA_WIDTH, TOTAL_FEATURE, FEATURE_WIDTH, ROW_WIDTH, ROW_LEN from the shared pooling parameter package.
REQ-032 SHALL instantiate one combinational sub-module fp_max (two operands, one result), used twice.

Verification
REQ-033 SHALL cover feature 0 rows 0/1 cols 0/1 = 1.0(3F800000), 2.0(40000000), -1.0(BF800000), 0.5(3F000000) -> one output 40000000, feature_row=1, one cycle after last input.
REQ-034 SHALL cover all-negative window -1.0, -2.0(C0000000), -3.0(C0400000), -1.5(BFC00000) -> 0xBF800000.
REQ-035 SHALL cover 4 features interleaved per cycle over rows 0-1 full width -> 12 outputs, correct feature_idx each, no seq_error.
REQ-036 SHALL cover +0(00000000) vs -0(80000000) in all positions -> 0x00000000 output, sign from first operand rule.
REQ-037 SHALL cover odd-col pixel without preceding even-col -> seq_error=1, stays 1 until reset.
REQ-038 SHALL cover reset asserted after row 0 then rows 0-1 replayed -> outputs from replayed data only, seq_error=0.
